// File: rtl/calc_result_display_if.sv
// ----------------------------------------------------------------------------
// calc_result_display_if : request/result bundle between calculator and display
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface calc_result_display_if;
  logic        Start;
  logic [15:0] Value;
  logic        Neg;
  logic        Err;
  logic        Busy;
  logic        Valid;
  logic [19:0] Bcd;
  logic [7:0]  An;
  logic [6:0]  Cathodes;
  logic        Dp;

  modport master (
    output Start, Value, Neg, Err,
    input  Busy, Valid, Bcd, An, Cathodes, Dp
  );

  modport slave (
    input  Start, Value, Neg, Err,
    output Busy, Valid, Bcd, An, Cathodes, Dp
  );
endinterface

`default_nettype wire

// File: rtl/calc_result_display.sv
// ----------------------------------------------------------------------------
// calc_result_display : serial binary-to-BCD conversion feeding a scanned
// 8-digit seven-segment display with blanking, minus sign and "Err".
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module calc_result_display #(
  parameter int SCAN_BITS = 18
) (
  input  wire logic Clk,
  input  wire logic Reset_n,
  calc_result_display_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_R     = 7'b1111010;

  logic [1:0]           state_q,    state_d;
  logic [15:0]          shift_q,    shift_d;
  logic [19:0]          acc_q,      acc_d;
  logic [3:0]           cnt_q,      cnt_d;
  logic                 busy_q,     busy_d;
  logic                 valid_q,    valid_d;
  logic [19:0]          bcd_q,      bcd_d;
  logic                 neg_sh_q,   neg_sh_d;
  logic                 err_sh_q,   err_sh_d;
  logic                 neg_disp_q, neg_disp_d;
  logic                 err_disp_q, err_disp_d;
  logic                 shown_q,    shown_d;
  logic [SCAN_BITS-1:0] scan_q;
  logic [7:0]           an_q,       an_d;
  logic [6:0]           cath_q,     cath_d;

  logic [19:0] acc_adj;
  logic [2:0]  sel;
  logic [3:0]  nib;
  logic [7:0]  keep;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Add-3 correction applied to every BCD nibble before each shift.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 5; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    valid_d    = valid_q;
    bcd_d      = bcd_q;
    neg_sh_d   = neg_sh_q;
    err_sh_d   = err_sh_q;
    neg_disp_d = neg_disp_q;
    err_disp_d = err_disp_q;
    shown_d    = shown_q;
    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          shift_d  = bus.Value;
          neg_sh_d = bus.Neg;
          err_sh_d = bus.Err;
          acc_d    = 20'd0;
          cnt_d    = 4'd0;
          busy_d   = 1'b1;
          valid_d  = 1'b0;
          state_d  = S_CONV;
        end
      end
      S_CONV: begin
        acc_d   = {acc_adj[18:0], shift_q[15]};
        shift_d = {shift_q[14:0], 1'b0};
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        bcd_d      = acc_q;
        neg_disp_d = neg_sh_q;
        err_disp_d = err_sh_q;
        shown_d    = 1'b1;
        valid_d    = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sel = scan_q[SCAN_BITS-1 -: 3];

  // keep[i]: digit i is significant (it or a higher digit is non-zero).
  always_comb begin
    keep    = 8'd0;
    keep[4] = |bcd_q[19:16];
    keep[3] = keep[4] | (|bcd_q[15:12]);
    keep[2] = keep[3] | (|bcd_q[11:8]);
    keep[1] = keep[2] | (|bcd_q[7:4]);
    keep[0] = 1'b1;
  end

  always_comb begin
    case (sel)
      3'd0:    nib = bcd_q[3:0];
      3'd1:    nib = bcd_q[7:4];
      3'd2:    nib = bcd_q[11:8];
      3'd3:    nib = bcd_q[15:12];
      3'd4:    nib = bcd_q[19:16];
      default: nib = 4'd0;
    endcase
  end

  always_comb begin
    cath_d = SEG_BLANK;
    if (!shown_q) begin
      cath_d = SEG_BLANK;
    end else if (err_disp_q) begin
      case (sel)
        3'd2:    cath_d = SEG_E;
        3'd1:    cath_d = SEG_R;
        3'd0:    cath_d = SEG_R;
        default: cath_d = SEG_BLANK;
      endcase
    end else if (sel <= 3'd4) begin
      if (keep[sel]) begin
        cath_d = seg7(nib);
      end
    end else if (sel == 3'd5 && neg_disp_q) begin
      cath_d = SEG_MINUS;
    end
  end

  assign an_d = ~(8'b1 << sel);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      shift_q    <= 16'd0;
      acc_q      <= 20'd0;
      cnt_q      <= 4'd0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      bcd_q      <= 20'd0;
      neg_sh_q   <= 1'b0;
      err_sh_q   <= 1'b0;
      neg_disp_q <= 1'b0;
      err_disp_q <= 1'b0;
      shown_q    <= 1'b0;
      scan_q     <= '0;
      an_q       <= 8'hFF;
      cath_q     <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      bcd_q      <= bcd_d;
      neg_sh_q   <= neg_sh_d;
      err_sh_q   <= err_sh_d;
      neg_disp_q <= neg_disp_d;
      err_disp_q <= err_disp_d;
      shown_q    <= shown_d;
      scan_q     <= scan_q + 1'b1;
      an_q       <= an_d;
      cath_q     <= cath_d;
    end
  end

  assign bus.Busy     = busy_q;
  assign bus.Valid    = valid_q;
  assign bus.Bcd      = bcd_q;
  assign bus.An       = an_q;
  assign bus.Cathodes = cath_q;
  assign bus.Dp       = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_calc_result_display.sv
// ----------------------------------------------------------------------------
// tb_calc_result_display : directed self-checking bench for calc_result_display
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_calc_result_display;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] SM = 7'b1111110;
  localparam logic [6:0] SE = 7'b0110000;
  localparam logic [6:0] SR = 7'b1111010;
  localparam logic [6:0] SB = 7'b1111111;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  calc_result_display_if bus ();

  calc_result_display #(.SCAN_BITS(4)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_conv(input logic [15:0] v, input logic n, input logic e);
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Value = v;
    bus.Neg   = n;
    bus.Err   = e;
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  task automatic check_digit(input int i, input logic [6:0] exp, input string name);
    logic [7:0] want_an;
    bit         found;
    want_an = ~(8'd1 << i);
    found   = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (bus.An === want_an) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s digit%0d: An never reached %b", name, i, want_an);
    end else if (bus.Cathodes !== exp) begin
      errors++;
      $display("FAIL %s digit%0d: Cathodes got %b want %b", name, i, bus.Cathodes, exp);
    end
  endtask

  // Runs a conversion and checks Busy/Valid timing and the latched Bcd.
  task automatic convert_and_check(input logic [15:0] v, input logic n, input logic e,
                                   input logic [19:0] exp_bcd, input string name);
    start_conv(v, n, e);
    checks++;
    if (bus.Busy !== 1'b1 || bus.Valid !== 1'b0) begin
      errors++;
      $display("FAIL %s start: Busy/Valid got %b%b want 10", name, bus.Busy, bus.Valid);
    end
    repeat (16) @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b1 || bus.Valid !== 1'b0) begin
      errors++;
      $display("FAIL %s k+16: Busy/Valid got %b%b want 10", name, bus.Busy, bus.Valid);
    end
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.Valid !== 1'b1 || bus.Bcd !== exp_bcd) begin
      errors++;
      $display("FAIL %s k+17: Busy/Valid %b%b Bcd %h want 01 %h",
               name, bus.Busy, bus.Valid, bus.Bcd, exp_bcd);
    end
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.Valid !== 1'b0 || bus.Bcd !== 20'd0 ||
        bus.An !== 8'hFF || bus.Cathodes !== SB || bus.Dp !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: Busy %b Valid %b Bcd %h An %h Cath %b Dp %b",
               bus.Busy, bus.Valid, bus.Bcd, bus.An, bus.Cathodes, bus.Dp);
    end
    rst_n = 1'b1;
    start_conv(16'd1234, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.Busy !== 1'b0 || bus.Valid !== 1'b0 || bus.Bcd !== 20'd0 ||
        bus.An !== 8'hFF || bus.Cathodes !== SB) begin
      errors++;
      $display("FAIL reset_async: Busy %b Valid %b Bcd %h An %h Cath %b",
               bus.Busy, bus.Valid, bus.Bcd, bus.An, bus.Cathodes);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.Cathodes !== SB || bus.Valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_blank: %0d non-blank/valid cycles, want 0", bad);
    end
  endtask

  task automatic test_1234();
    convert_and_check(16'd1234, 1'b0, 1'b0, 20'h01234, "v1234");
    check_digit(0, S4, "v1234");
    check_digit(1, S3, "v1234");
    check_digit(2, S2, "v1234");
    check_digit(3, S1, "v1234");
    for (int i = 4; i < 8; i++) check_digit(i, SB, "v1234");
  endtask

  task automatic test_max_and_zero();
    convert_and_check(16'hFFFF, 1'b0, 1'b0, 20'h65535, "vffff");
    check_digit(4, S6, "vffff");
    check_digit(3, S5, "vffff");
    check_digit(2, S5, "vffff");
    check_digit(1, S3, "vffff");
    check_digit(0, S5, "vffff");
    check_digit(5, SB, "vffff");
    convert_and_check(16'd0, 1'b0, 1'b0, 20'h00000, "v0");
    check_digit(0, S0, "v0");
    for (int i = 1; i < 8; i++) check_digit(i, SB, "v0");
  endtask

  task automatic test_negative();
    convert_and_check(16'd42, 1'b1, 1'b0, 20'h00042, "neg42");
    check_digit(0, S2, "neg42");
    check_digit(1, S4, "neg42");
    check_digit(5, SM, "neg42");
    for (int i = 2; i < 5; i++) check_digit(i, SB, "neg42");
    check_digit(6, SB, "neg42");
    check_digit(7, SB, "neg42");
  endtask

  task automatic test_error();
    convert_and_check(16'd7, 1'b1, 1'b1, 20'h00007, "err7");
    check_digit(2, SE, "err7");
    check_digit(1, SR, "err7");
    check_digit(0, SR, "err7");
    check_digit(3, SB, "err7");
    check_digit(5, SB, "err7");
    convert_and_check(16'd5, 1'b0, 1'b0, 20'h00005, "clr5");
    check_digit(0, S5, "clr5");
    check_digit(1, SB, "clr5");
    check_digit(2, SB, "clr5");
  endtask

  task automatic test_hold_during_conv();
    bit got;
    start_conv(16'd1234, 1'b0, 1'b0);
    check_digit(0, S5, "hold");
    checks++;
    if (bus.Valid !== 1'b0 || bus.Busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_busy: Busy/Valid got %b%b want 10", bus.Busy, bus.Valid);
    end
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      if (bus.Valid === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || bus.Bcd !== 20'h01234) begin
      errors++;
      $display("FAIL hold_done: Valid %b Bcd %h want 1 01234", bus.Valid, bus.Bcd);
    end
  endtask

  task automatic test_back_to_back();
    start_conv(16'd500, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    bus.Start = 1'b1;
    bus.Value = 16'd99;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (11) @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy: Busy got %b want 1", bus.Busy);
    end
    @(negedge clk);
    checks++;
    if (bus.Valid !== 1'b1 || bus.Bcd !== 20'h00500) begin
      errors++;
      $display("FAIL b2b_ignored: Valid %b Bcd %h want 1 00500", bus.Valid, bus.Bcd);
    end
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.Valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: Busy/Valid got %b%b want 01", bus.Busy, bus.Valid);
    end
    convert_and_check(16'd99, 1'b0, 1'b0, 20'h00099, "v99");
    check_digit(1, 7'b0000100, "v99");
    check_digit(2, SB, "v99");
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.Start = 1'b0;
    bus.Value = 16'd0;
    bus.Neg   = 1'b0;
    bus.Err   = 1'b0;
    test_reset();
    test_1234();
    test_max_and_zero();
    test_negative();
    test_error();
    test_hold_during_conv();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
